// File: rtl/ofm_rd_addr_controller_pkg.sv
// -----------------------------------------------------------------------------
// ofm_rd_addr_controller_pkg
//
// Shared definitions for the output-feature-map address controllers:
//   - ofm_rd_state_e : state encoding of the read-address sequencer
//   - calc_plane     : words per channel plane (OFM_SIZE * OFM_SIZE)
//   - calc_num_tiles : tiles needed to cover a plane, including a partial
//                      last tile
// -----------------------------------------------------------------------------
package ofm_rd_addr_controller_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        TILE_ADV = 2'd2,
        DONE     = 2'd3
    } ofm_rd_state_e;

    function automatic int unsigned calc_plane(input int unsigned ofm_size);
        return ofm_size * ofm_size;
    endfunction

    function automatic int unsigned calc_num_tiles(input int unsigned plane,
                                                   input int unsigned tile);
        return (plane + tile - 1) / tile;
    endfunction

endpackage

// File: rtl/ofm_rd_addr_controller.sv
// -----------------------------------------------------------------------------
// ofm_rd_addr_controller
//
// Walks an output feature map tile by tile. For every tile of SYSTOLIC_SIZE
// pixels it issues one burst per channel plane (NUM_CHANNEL bursts), each
// burst starting at base + ch*PLANE. The last tile of a plane may be partial,
// in which case the burst length is the remaining word count.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : single-cycle frame request, honoured only in IDLE
//   rd_ready   : consumer accepts the current address (used only with rd_valid)
//   rd_addr    : word start address of the current burst
//   rd_len     : words in the current burst
//   rd_valid   : rd_addr / rd_len / rd_last_ch are valid
//   rd_last_ch : current burst is the last channel of the tile
//   busy       : controller is not IDLE
//   done       : one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module ofm_rd_addr_controller
    import ofm_rd_addr_controller_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 414,
    parameter int NUM_CHANNEL   = 16,
    parameter int ADDR_WIDTH    = 22
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 rd_ready,
    output logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [$clog2(SYSTOLIC_SIZE+1)-1:0]   rd_len,
    output logic                                 rd_valid,
    output logic                                 rd_last_ch,
    output logic                                 busy,
    output logic                                 done
);

    localparam int LEN_W = $clog2(SYSTOLIC_SIZE + 1);
    localparam int CH_W  = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

    localparam logic [ADDR_WIDTH-1:0] PLANE    = ADDR_WIDTH'(calc_plane(OFM_SIZE));
    localparam logic [ADDR_WIDTH-1:0] TILE     = ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CHANNEL - 1);
    localparam logic [LEN_W-1:0]      FULL_LEN = LEN_W'(SYSTOLIC_SIZE);
    // With a single channel the first beat of a tile is also its last.
    localparam logic                  FIRST_IS_LAST = (NUM_CHANNEL == 1);

    // Burst length for a tile starting at 'base': a full tile, or whatever
    // is left of the plane for the partial last tile.
    function automatic logic [LEN_W-1:0] burst_len(input logic [ADDR_WIDTH-1:0] base);
        logic [ADDR_WIDTH-1:0] remain;
        remain = PLANE - base;
        if (remain >= TILE) begin
            return FULL_LEN;
        end
        return LEN_W'(remain);
    endfunction

    ofm_rd_state_e          r_state;
    ofm_rd_state_e          w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH-1:0]  w_base_nxt;
    logic [CH_W-1:0]        r_ch;
    logic [CH_W-1:0]        w_ch_nxt;
    // Running ch*PLANE, built by accumulation rather than multiplication.
    logic [ADDR_WIDTH-1:0]  r_ch_off;
    logic [ADDR_WIDTH-1:0]  w_ch_off_nxt;

    logic [ADDR_WIDTH-1:0]  r_rd_addr;
    logic [ADDR_WIDTH-1:0]  w_rd_addr_nxt;
    logic [LEN_W-1:0]       r_rd_len;
    logic [LEN_W-1:0]       w_rd_len_nxt;
    logic                   r_rd_valid;
    logic                   w_rd_valid_nxt;
    logic                   r_rd_last_ch;
    logic                   w_rd_last_ch_nxt;
    logic                   r_done;
    logic                   w_done_nxt;

    logic                   w_accept;

    assign w_accept = r_rd_valid && rd_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered so each
    // value computed here appears on the cycle after the deciding edge.
    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_ch_nxt         = r_ch;
        w_ch_off_nxt     = r_ch_off;
        w_rd_addr_nxt    = r_rd_addr;
        w_rd_len_nxt     = r_rd_len;
        w_rd_valid_nxt   = r_rd_valid;
        w_rd_last_ch_nxt = r_rd_last_ch;
        w_done_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt      = ISSUE;
                    w_base_nxt       = '0;
                    w_ch_nxt         = '0;
                    w_ch_off_nxt     = '0;
                    w_rd_addr_nxt    = '0;
                    w_rd_len_nxt     = burst_len('0);
                    w_rd_valid_nxt   = 1'b1;
                    w_rd_last_ch_nxt = FIRST_IS_LAST;
                end
            end

            ISSUE: begin
                if (w_accept) begin
                    if (r_ch != LAST_CH) begin
                        // Next channel of the same tile, back-to-back.
                        w_ch_nxt         = r_ch + CH_W'(1);
                        w_ch_off_nxt     = r_ch_off + PLANE;
                        w_rd_addr_nxt    = r_base + r_ch_off + PLANE;
                        w_rd_last_ch_nxt = ((r_ch + CH_W'(1)) == LAST_CH);
                    end else begin
                        w_state_nxt      = TILE_ADV;
                        w_rd_valid_nxt   = 1'b0;
                        w_rd_last_ch_nxt = 1'b0;
                        w_base_nxt       = r_base + TILE;
                        w_ch_nxt         = '0;
                        w_ch_off_nxt     = '0;
                    end
                end
            end

            TILE_ADV: begin
                if (r_base < PLANE) begin
                    w_state_nxt      = ISSUE;
                    w_rd_addr_nxt    = r_base;
                    w_rd_len_nxt     = burst_len(r_base);
                    w_rd_valid_nxt   = 1'b1;
                    w_rd_last_ch_nxt = FIRST_IS_LAST;
                end else begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_base_nxt  = '0;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base       <= '0;
            r_ch         <= '0;
            r_ch_off     <= '0;
            r_rd_addr    <= '0;
            r_rd_len     <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last_ch <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_base       <= w_base_nxt;
            r_ch         <= w_ch_nxt;
            r_ch_off     <= w_ch_off_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_len     <= w_rd_len_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_rd_last_ch <= w_rd_last_ch_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign rd_addr    = r_rd_addr;
    assign rd_len     = r_rd_len;
    assign rd_valid   = r_rd_valid;
    assign rd_last_ch = r_rd_last_ch;
    assign done       = r_done;
    assign busy       = (r_state != IDLE);

endmodule
